// File: rtl/microchip_sle_pkg.sv
// Shared constants and helpers for the SLE-class elastic register pipeline.
package microchip_sle_pkg;

    // Encodings for the CLR_OVER_EN parameter.
    localparam int unsigned CLR_PRIO_EN  = 0;  // Clear only acts when En=1
    localparam int unsigned CLR_PRIO_CLR = 1;  // Clear acts regardless of En

    // Width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned clog2_safe(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/microchip_sle_pipe_stage.sv
// One WIDTH-bit pipeline stage: valid and data flops with async init,
// sync clear and load-on-go. Data only toggles when a valid beat arrives.
module microchip_sle_pipe_stage
    import microchip_sle_pkg::*;
#(
    parameter int unsigned          WIDTH   = 8,
    parameter logic [WIDTH-1:0]     INIT    = '0,
    parameter logic [WIDTH-1:0]     CLR_VAL = '0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             clear,
    input  logic             go,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    // Stage state: Reset > clear > go; data held when the incoming beat is a bubble.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            valid <= 1'b0;
            data  <= INIT;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= CLR_VAL;
        end else if (go) begin
            valid <= prev_valid;
            if (prev_valid) begin
                data <= prev_data;
            end
        end
    end

endmodule

// File: rtl/microchip_sle_pipe.sv
// Elastic register pipeline of DEPTH SLE-class stages with valid/ready on both
// ends. Bubbles collapse through the combinational go chain.
module microchip_sle_pipe
    import microchip_sle_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      DEPTH       = 2,
    parameter logic [WIDTH-1:0] INIT        = '0,
    parameter logic [WIDTH-1:0] CLR_VAL     = '0,
    parameter int unsigned      CLR_OVER_EN = CLR_PRIO_CLR
) (
    input  logic                         CLK,
    input  logic                         Reset,
    input  logic                         En,
    input  logic                         Clear,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = clog2_safe(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] prev_v;
    logic [WIDTH-1:0] prev_d [DEPTH];
    logic [DEPTH:0]   go;
    logic             clear_eff;
    logic             push;
    logic             pop;
    logic             all_full;
    logic [CW-1:0]    count_q;

    // Clear either overrides En or is gated by it.
    assign clear_eff = Clear & ((CLR_OVER_EN == CLR_PRIO_CLR) ? 1'b1 : En);

    // go[i] = En & (!v[i] | go[i+1]) unrolled: a stage moves if downstream pops
    // or any stage at or beyond it is a bubble.
    always_comb begin
        all_full  = 1'b1;
        go        = '0;
        go[DEPTH] = En & out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            all_full = all_full & v[i];
            go[i]    = En & (out_ready | ~all_full);
        end
    end

    // Stage inputs: stage 0 from the upstream port, others from the previous stage.
    always_comb begin
        prev_v    = '0;
        prev_v[0] = in_valid;
        prev_d[0] = in_data;
        for (int i = 1; i < int'(DEPTH); i++) begin
            prev_v[i] = v[i-1];
            prev_d[i] = d[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        microchip_sle_pipe_stage #(
            .WIDTH   (WIDTH),
            .INIT    (INIT),
            .CLR_VAL (CLR_VAL)
        ) u_stage (
            .CLK        (CLK),
            .Reset      (Reset),
            .clear      (clear_eff),
            .go         (go[g]),
            .prev_valid (prev_v[g]),
            .prev_data  (prev_d[g]),
            .valid      (v[g]),
            .data       (d[g])
        );
    end

    assign in_ready  = go[0] & ~Reset & ~Clear;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign push = in_valid & in_ready;
    assign pop  = v[DEPTH-1] & go[DEPTH];

    // Occupancy counter tracking popcount(v) incrementally.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (clear_eff) begin
            count_q <= '0;
        end else if (push && !pop) begin
            count_q <= count_q + CW'(1);
        end else if (pop && !push) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge CLK) disable iff (Reset)
        count_q <= CW'(DEPTH));
    a_no_overflow: assert property (@(posedge CLK) disable iff (Reset)
        !(!clear_eff && push && !pop && count_q == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge CLK) disable iff (Reset)
        !(!clear_eff && pop && !push && count_q == '0));
`endif

endmodule
